// File: rtl/selfcon_ctrl.sv
// selfcon_ctrl -- self-convergence controller for the BISG scan test loop.
//
// Sequences repeated BIST runs of the CUT. Each run pulses the CUT reset,
// presents ScanNum, and waits for the CUT to report completion. The speed code
// captured at the end of the run becomes a path-delay estimate. The controller
// grows ScanNum until K delay estimates have stayed within EPS of the
// preceding estimate. It also captures the golden signature on the first scan
// of the first run and reports whether later signatures still match it.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   go         in   start request, honoured only when idle or finished
//   over       in   CUT run-complete level
//   scan_done  in   CUT per-scan completion level (rising edge = one scan)
//   sig        in   CUT signature [SIG_W]
//   speed      in   CUT captured speed code [SPEED_W]
//   cut_rst_n  out  active-low reset to the CUT
//   ScanNum    out  scan count presented to the CUT [SCAN_W]
//   pass       out  signature matches golden
//   dmax       out  latest delay estimate, 10 ps units [DMAX_W]
//   run_cnt    out  completed runs
//   conv_cnt   out  convergence hits
//   busy       out  sequence in progress
//   done       out  sequence finished
//   converged  out  finished because K hits were reached
module selfcon_ctrl #(
  parameter int SIG_W      = 13,
  parameter int SCAN_W     = 20,
  parameter int SPEED_W    = 10,
  parameter int DMAX_W     = 14,
  parameter int SCAN_START = 60,
  parameter int SCAN_BASE  = 10,
  parameter int K          = 8,
  parameter int EPS        = 10,
  parameter int MAX_RUNS   = 64,
  parameter int RST_CYC    = 3,
  parameter int MULT_MAX   = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               over,
  input  logic               scan_done,
  input  logic [SIG_W-1:0]   sig,
  input  logic [SPEED_W-1:0] speed,
  output logic               cut_rst_n,
  output logic [SCAN_W-1:0]  ScanNum,
  output logic               pass,
  output logic [DMAX_W-1:0]  dmax,
  output logic [7:0]         run_cnt,
  output logic [7:0]         conv_cnt,
  output logic               busy,
  output logic               done,
  output logic               converged
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_ARM,
    S_RUN,
    S_EVAL,
    S_UPD,
    S_DONE
  } state_t;

  // Multiplier register must hold MULT_MAX itself.
  localparam int MULT_W = $clog2(MULT_MAX) + 1;
  localparam int CNT_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  // Width of one increment (mult * SCAN_BASE), and of ScanNum + increment
  // with one guard bit so saturation can be detected.
  localparam int INC_W  = MULT_W + $clog2(SCAN_BASE + 1);
  localparam int SUM_W  = ((SCAN_W > INC_W) ? SCAN_W : INC_W) + 1;
  localparam logic [SUM_W-1:0] SCAN_SAT = {{(SUM_W-SCAN_W){1'b0}}, {SCAN_W{1'b1}}};

  // Delay estimate from the speed code. Codes above 20 sit on the slow
  // branch with a 1000 offset; the rest use 900. Max 11230 fits DMAX_W.
  function automatic logic [DMAX_W-1:0] delay_est(input logic [SPEED_W-1:0] s);
    logic [DMAX_W-1:0] scaled;
    scaled = DMAX_W'(s) * DMAX_W'(10);
    if (s > SPEED_W'(20))
      delay_est = scaled + DMAX_W'(1000);
    else
      delay_est = scaled + DMAX_W'(900);
  endfunction

  // Double the bounce multiplier, clamped at MULT_MAX.
  function automatic logic [MULT_W-1:0] mult_step(input logic [MULT_W-1:0] m);
    logic [MULT_W:0] dbl;
    dbl = {m, 1'b0};
    if (dbl > (MULT_W+1)'(MULT_MAX))
      mult_step = MULT_W'(MULT_MAX);
    else
      mult_step = dbl[MULT_W-1:0];
  endfunction

  // ScanNum + m*SCAN_BASE, saturating at the all-ones ScanNum value.
  function automatic logic [SCAN_W-1:0] scan_sat_add(input logic [SCAN_W-1:0] base,
                                                     input logic [MULT_W-1:0] m);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(base) + SUM_W'(m) * SUM_W'(SCAN_BASE);
    if (sum > SCAN_SAT)
      scan_sat_add = {SCAN_W{1'b1}};
    else
      scan_sat_add = sum[SCAN_W-1:0];
  endfunction

  state_t              state;
  logic [CNT_W-1:0]    rst_cnt;
  logic [MULT_W-1:0]   mult;
  logic [DMAX_W-1:0]   prev_d;
  logic [SIG_W-1:0]    golden;
  logic                golden_valid;
  logic [SPEED_W-1:0]  spd_lat;
  logic                sd_prev;

  logic                sd_rise;
  logic                hit;
  logic [MULT_W-1:0]   mult_nx;
  logic [7:0]          conv_nx;
  logic [7:0]          run_nx;
  logic [SCAN_W-1:0]   scan_nx;

  assign sd_rise = scan_done & ~sd_prev;

  // Update-step arithmetic; only consumed in S_UPD, where dmax already holds
  // this run's estimate. The first run never counts as a hit.
  always_comb begin
    hit     = (run_cnt != 8'd0) &&
              ({1'b0, dmax} <= ({1'b0, prev_d} + (DMAX_W+1)'(EPS)));
    mult_nx = hit ? mult_step(mult) : mult;
    conv_nx = hit ? conv_cnt + 8'd1 : conv_cnt;
    run_nx  = run_cnt + 8'd1;
    scan_nx = scan_sat_add(ScanNum, mult_nx);
  end

  // scan_done history for edge detection; pure data, no reset needed.
  always_ff @(posedge clk) begin
    sd_prev <= scan_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rst_cnt      <= '0;
      cut_rst_n    <= 1'b1;
      ScanNum      <= SCAN_W'(SCAN_START);
      pass         <= 1'b0;
      dmax         <= '0;
      run_cnt      <= 8'd0;
      conv_cnt     <= 8'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      converged    <= 1'b0;
      mult         <= MULT_W'(1);
      prev_d       <= '0;
      golden_valid <= 1'b0;
    end else begin
      case (state)
        // Start (or restart after a finished sequence).
        S_IDLE, S_DONE: begin
          if (go) begin
            state        <= S_CRST;
            rst_cnt      <= '0;
            cut_rst_n    <= 1'b0;
            ScanNum      <= SCAN_W'(SCAN_START);
            pass         <= 1'b0;
            run_cnt      <= 8'd0;
            conv_cnt     <= 8'd0;
            busy         <= 1'b1;
            done         <= 1'b0;
            converged    <= 1'b0;
            mult         <= MULT_W'(1);
            prev_d       <= '0;
            golden_valid <= 1'b0;
          end
        end

        // Hold the CUT in reset for RST_CYC cycles in total.
        S_CRST: begin
          if (rst_cnt == CNT_W'(RST_CYC - 1)) begin
            state     <= S_ARM;
            cut_rst_n <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + CNT_W'(1);
          end
        end

        // A leftover over=1 from the previous run must drop before we listen.
        S_ARM: begin
          if (!over)
            state <= S_RUN;
        end

        // Scan events update the signature status; over ends the run. A scan
        // edge arriving together with over is still processed.
        S_RUN: begin
          if (sd_rise) begin
            if (!golden_valid && run_cnt == 8'd0) begin
              golden       <= sig;
              golden_valid <= 1'b1;
              pass         <= 1'b1;
            end else begin
              pass <= (sig == golden);
            end
          end
          if (over) begin
            spd_lat <= speed;
            state   <= S_EVAL;
          end
        end

        S_EVAL: begin
          dmax  <= delay_est(spd_lat);
          state <= S_UPD;
        end

        // Convergence bookkeeping and exit decision.
        S_UPD: begin
          mult     <= mult_nx;
          conv_cnt <= conv_nx;
          run_cnt  <= run_nx;
          ScanNum  <= scan_nx;
          prev_d   <= dmax;
          if (conv_nx == 8'(K)) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            converged <= 1'b1;
          end else if (run_nx == 8'(MAX_RUNS)) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            converged <= 1'b0;
          end else begin
            state     <= S_CRST;
            rst_cnt   <= '0;
            cut_rst_n <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/selfcon_ctrl.md
# selfcon_ctrl

On-chip self-convergence controller for the BISG scan test loop. It sequences repeated BIST runs of `BISG_TOP`: it pulses the CUT reset, supplies `ScanNum`, and waits for `over`. It then converts the captured `speed` code into a path-delay estimate and grows `ScanNum` until K consecutive-or-cumulative delay estimates stay within epsilon. It also holds the golden signature and reports `pass`, replacing the bench-driven convergence loop so silicon runs it standalone.

## Interface
- `SIG_W`, 13, signature width
- `SCAN_W`, 20, ScanNum width
- `SPEED_W`, 10, speed code width
- `DMAX_W`, 14, delay estimate width (units 10 ps)
- `SCAN_START`, 60, initial ScanNum
- `SCAN_BASE`, 10, ScanNum increment base
- `K`, 8, convergence hits required
- `EPS`, 10, convergence tolerance (delay units)
- `MAX_RUNS`, 64, run limit before giving up
- `RST_CYC`, 3, CUT reset low duration in cycles
- `MULT_MAX`, 128, saturation value of bounce multiplier (power of two)

Ports:
- `clk` in 1: system clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `go` in 1: start request, sampled in IDLE/DONE
- `over` in 1: CUT run-complete level
- `scan_done` in 1: CUT per-scan completion level
- `sig` in SIG_W: CUT signature
- `speed` in SPEED_W: CUT captured speed code
- `cut_rst_n` out 1: drives CUT `rst_n`
- `ScanNum` out SCAN_W: scan count for CUT
- `pass` out 1: signature status
- `dmax` out DMAX_W: latest delay estimate
- `run_cnt` out 8: completed runs
- `conv_cnt` out 8: convergence hits
- `busy` out 1: sequence in progress
- `done` out 1: sequence finished
- `converged` out 1: finished by reaching K hits

## Operation
- States: IDLE, CRST, ARM, RUN, EVAL, UPD, DONE.
- IDLE: `go`=1 → CRST. Clears run_cnt, conv_cnt, mult=1, prev_d=0, golden_valid=0, pass=0. Loads ScanNum=SCAN_START.
- CRST: `cut_rst_n`=0 for exactly RST_CYC cycles → ARM.
- ARM: wait `over`=0 → RUN. A stale `over`=1 from the previous run is never accepted.
- RUN: each rising edge of `scan_done` (0→1 between consecutive samples) is one scan event.
  - First event of run 0 with golden_valid=0: golden←sig, golden_valid=1, pass←1.
  - Every other event: pass←(sig==golden).
  - `over`=1 → EVAL, with speed latched that cycle. A `scan_done` rise in that same cycle is still processed.
- EVAL: d = (speed>20) ? 1000+10·speed : 900+10·speed, computed in DMAX_W bits with no overflow (speed≤1023 → d≤11230). dmax←d.
- UPD:
  - Hit when run_cnt>0 and d ≤ prev_d+EPS (unsigned compare, prev_d+EPS in DMAX_W+1 bits). A decrease counts as a hit.
  - On hit: mult←min(2·mult, MULT_MAX), conv_cnt++.
  - Then ScanNum←ScanNum+mult·SCAN_BASE using the new mult, saturating at 2^SCAN_W−1.
  - prev_d←d; run_cnt++.
  - Exit: conv_cnt==K → DONE, converged=1. Else run_cnt==MAX_RUNS → DONE, converged=0. Else → CRST.
- DONE: outputs held. `go`=1 → restart as from IDLE.
- `busy`=1 in all states except IDLE and DONE. `done`=1 only in DONE.

## Timing
- Reset values: state IDLE, `cut_rst_n`=1, ScanNum=SCAN_START, pass=0, dmax=0, run_cnt=0, conv_cnt=0, busy=0, done=0, converged=0.
- `rst` mid-sequence aborts at the next edge: all outputs return to reset values and `cut_rst_n` goes high.
- `go`→`cut_rst_n` low: 1 cycle.
- `over` seen high → new ScanNum visible: 2 cycles (EVAL, UPD). `cut_rst_n` falls on the cycle after UPD.
- `go` is ignored while busy.
- All outputs are registered.

## Test plan
- Reset then go: `cut_rst_n` low exactly 3 cycles. ScanNum=60. After ARM sees over=0, the bench raises over with speed=30 → dmax=1300, ScanNum=70, run_cnt=1, conv_cnt=0.
- Convergence doubling: speeds 30,30,31 → ScanNum 60→70→90→130, conv_cnt 0,1,2, mult 1,2,4.
- Boundary: prev_d=1300, speed=31 (d=1310) → hit; speed=32 (d=1320 > 1310) → no hit, ScanNum +mult·10 with mult unchanged. speed=20 → d=1100 (900 branch); speed=21 → d=1210.
- K=8 constant speeds: done=1, converged=1 after run 9. mult saturates at 128, so ScanNum increments are capped at 1280.
- Signatures: first scan_done sig=0x0A5 sets golden, pass=1. A later scan with sig=0x0A4 → pass=0. The next matching scan → pass=1.
- MAX_RUNS=4 with strictly rising speeds (+5 each) → done=1, converged=0, run_cnt=4. Asserting rst during RUN → `cut_rst_n`=1 and all outputs at reset values next cycle.
